// File: rtl/row_window_ctrl_pkg.sv
// row_window_ctrl_pkg: FSM encoding and window geometry shared by the row window sequencer.
package row_window_ctrl_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROW   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int WIN_TAPS   = 3;
  localparam int DRAIN_POPS = WIN_TAPS - 1;
  localparam int DRAIN_CW   = $clog2(DRAIN_POPS + 1);
endpackage

// File: rtl/row_window_ctrl.sv
// row_window_ctrl: writes a pixel stream into a pop-1/read-3 FIFO, pops one window per column,
// flushes the row tail so windows never span rows, and tags the FIFO read data.
module row_window_ctrl
  import row_window_ctrl_pkg::*;
#(
  parameter int DAT_WIDTH     = 8,
  parameter int FF_ADDR_WIDTH = 3,
  parameter int DIM_WIDTH     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DIM_WIDTH-1:0]     cfg_row_len,
  input  logic [DIM_WIDTH-1:0]     cfg_num_rows,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  input  logic                     in_valid,
  input  logic [DAT_WIDTH-1:0]     in_data,
  output logic                     in_ready,
  input  logic                     out_stall,
  output logic                     ff_wr_req,
  output logic [DAT_WIDTH-1:0]     ff_wr_data,
  output logic                     ff_rd_req,
  input  logic                     ff_rd_data_val,
  input  logic [FF_ADDR_WIDTH:0]   ff_data_counter,
  input  logic                     ff_full,
  output logic                     win_valid,
  output logic                     win_last,
  output logic                     win_last_row
);
  logic [1:0]           state;
  logic [DIM_WIDTH-1:0] row_len, len_m2, len_m3, rows_m1;
  logic [DIM_WIDTH-1:0] row_cnt, wr_col, rd_col;
  logic [DRAIN_CW-1:0]  drain_cnt;
  logic                 keep_q, last_q, lrow_q;
  logic                 cfg_ok, win_pop, last_pop, last_row, drain_end;

  always_comb begin
    cfg_ok       = (cfg_row_len >= DIM_WIDTH'(WIN_TAPS)) && (cfg_num_rows != '0);
    last_pop     = rd_col == len_m3;
    last_row     = row_cnt == rows_m1;
    drain_end    = (state == S_DRAIN) && (drain_cnt == DRAIN_CW'(DRAIN_POPS - 1));
    in_ready     = (state == S_ROW) && (wr_col < row_len) && !ff_full;
    ff_wr_req    = in_valid && in_ready;
    ff_wr_data   = in_data;
    win_pop      = (state == S_ROW) && (rd_col < len_m2) &&
                   (ff_data_counter >= (FF_ADDR_WIDTH+1)'(WIN_TAPS)) && !out_stall;
    // tail-discard pops ignore back-pressure: their data is never presented
    ff_rd_req    = win_pop || (state == S_DRAIN);
    busy         = state != S_IDLE;
    done         = state == S_DONE;
    win_valid    = ff_rd_data_val && keep_q;
    win_last     = win_valid && last_q;
    win_last_row = win_valid && lrow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      row_len   <= '0;
      len_m2    <= '0;
      len_m3    <= '0;
      rows_m1   <= '0;
      row_cnt   <= '0;
      wr_col    <= '0;
      rd_col    <= '0;
      drain_cnt <= '0;
      keep_q    <= 1'b0;
      last_q    <= 1'b0;
      lrow_q    <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= (state == S_IDLE) && start && !cfg_ok;
      keep_q  <= win_pop;
      last_q  <= win_pop && last_pop;
      lrow_q  <= last_row;
      if (ff_wr_req) wr_col <= wr_col + 1'b1;
      if (win_pop) rd_col <= rd_col + 1'b1;
      if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      case (state)
        S_IDLE: if (start && cfg_ok) begin
          row_len <= cfg_row_len;
          len_m2  <= cfg_row_len - DIM_WIDTH'(DRAIN_POPS);
          len_m3  <= cfg_row_len - DIM_WIDTH'(WIN_TAPS);
          rows_m1 <= cfg_num_rows - 1'b1;
          row_cnt <= '0;
          wr_col  <= '0;
          rd_col  <= '0;
          state   <= S_ROW;
        end
        S_ROW: if (win_pop && last_pop) begin
          drain_cnt <= '0;
          state     <= S_DRAIN;
        end
        S_DRAIN: if (drain_end) begin
          drain_cnt <= '0;
          wr_col    <= '0;
          rd_col    <= '0;
          row_cnt   <= last_row ? row_cnt : row_cnt + 1'b1;
          state     <= last_row ? S_DONE : S_ROW;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_row_window_ctrl.sv
// tb_row_window_ctrl: random and directed frames through the controller plus a behavioural pop1/read3 FIFO.
module tb_row_window_ctrl;
  localparam int DW = 8, AW = 3, NW = 10, DEPTH = 8;

  logic clk = 0, rst = 1, start = 0;
  logic [NW-1:0] cfg_row_len = '0, cfg_num_rows = '0;
  logic busy, done, cfg_err, in_valid = 0, in_ready, out_stall = 0;
  logic [DW-1:0] in_data = '0, ff_wr_data;
  logic ff_wr_req, ff_rd_req, ff_rd_data_val, ff_full;
  logic [AW:0] ff_data_counter;
  logic win_valid, win_last, win_last_row;
  logic [3*DW-1:0] rd_data;

  typedef struct {logic [3*DW-1:0] win; logic last; logic lrow;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, drain_from = -10, done_due = -1;

  always #5 clk = ~clk;

  row_window_ctrl #(.DAT_WIDTH(DW), .FF_ADDR_WIDTH(AW), .DIM_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows),
    .busy(busy), .done(done), .cfg_err(cfg_err), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_stall(out_stall), .ff_wr_req(ff_wr_req), .ff_wr_data(ff_wr_data),
    .ff_rd_req(ff_rd_req), .ff_rd_data_val(ff_rd_data_val), .ff_data_counter(ff_data_counter),
    .ff_full(ff_full), .win_valid(win_valid), .win_last(win_last), .win_last_row(win_last_row)
  );

  // behavioural FIFO: pop one entry, read data shows the three oldest entries (newest tap in MSBs)
  logic [DW-1:0] fq[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      ff_data_counter <= '0;
      ff_full <= 1'b0;
      ff_rd_data_val <= 1'b0;
      rd_data <= '0;
    end else begin
      ff_rd_data_val <= ff_rd_req;
      if (ff_rd_req) begin
        rd_data <= {fq.size() > 2 ? fq[2] : 8'h0, fq.size() > 1 ? fq[1] : 8'h0, fq.size() > 0 ? fq[0] : 8'h0};
        if (fq.size() > 0) void'(fq.pop_front());
      end
      if (ff_wr_req) fq.push_back(ff_wr_data);
      ff_data_counter <= (AW+1)'(fq.size());
      ff_full <= fq.size() >= DEPTH;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (win_valid) begin
        if (exp_q.size() == 0) chk("unexpected_window", {rd_data, win_last, win_last_row}, 64'hx);
        else begin
          e = exp_q.pop_front();
          chk("window", {rd_data, win_last, win_last_row}, {e.win, e.last, e.lrow});
        end
        if (win_last) drain_from = cyc;
        if (win_last && win_last_row) done_due = cyc + 2;
      end
      if (cyc == drain_from || cyc == drain_from + 1) chk("in_ready_in_drain", in_ready, 0);
      if (cyc == drain_from + 1 || cyc == drain_from + 2) chk("discard_pop", {ff_rd_data_val, win_valid}, 2'b10);
      if (done) chk("done_timing", cyc, done_due);
      if (ff_full) chk("in_ready_when_full", in_ready, 0);
    end
  end

  // mode bits: 1 random valid/stall, 2 long stall, 4 start poke in drain, 8 reset mid row 2,
  // 16 pixels (r+1)*10+c, 32 pixels c+1
  task automatic run_frame(int len, int rows, int mode);
    logic [DW-1:0] pix[$];
    exp_t e;
    int idx = 0, guard = 0, st = 0, total = len * rows;
    bit poked = 0, found = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < len; c++)
        pix.push_back((mode & 16) ? DW'((r + 1) * 10 + c) : (mode & 32) ? DW'(c + 1) : DW'($urandom));
    for (int r = 0; r < rows; r++)
      for (int i = 0; i <= len - 3; i++) begin
        e.win = {pix[r*len+i+2], pix[r*len+i+1], pix[r*len+i]};
        e.last = (i == len - 3);
        e.lrow = (r == rows - 1);
        exp_q.push_back(e);
      end
    @(negedge clk);
    cfg_row_len = NW'(len);
    cfg_num_rows = NW'(rows);
    start = 1;
    @(negedge clk);
    start = 0;
    while (idx < total && guard < 5000) begin
      in_valid = (mode & 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = pix[idx];
      out_stall = (mode & 2) ? (idx >= 8 && st < 10) : (mode & 1) ? ($urandom_range(0, 4) == 0) : 1'b0;
      if (out_stall && (mode & 2)) st++;
      if ((mode & 4) && win_last && !poked) begin
        start = 1;
        cfg_row_len = 3;
        cfg_num_rows = 1;
        poked = 1;
      end else start = 0;
      @(posedge clk);
      if (ff_wr_req) idx++;
      if ((mode & 8) && idx == len + len / 2) begin
        #2 rst = 1;
        #1 chk("async_reset_outputs",
               {busy, done, cfg_err, in_ready, ff_wr_req, ff_rd_req, win_valid, win_last, win_last_row}, 0);
        exp_q.delete();
        drain_from = -10;
        done_due = -1;
        in_valid = 0;
        out_stall = 0;
        start = 0;
        @(negedge clk);
        rst = 0;
        return;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 0;
    out_stall = 0;
    start = 0;
    chk("pixels_accepted", idx, total);
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      found = done;
    end
    chk("done_seen", found, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("windows_outstanding", exp_q.size(), 0);
  endtask

  task automatic bad_cfg(int len, int rows);
    @(negedge clk);
    cfg_row_len = NW'(len);
    cfg_num_rows = NW'(rows);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("cfg_err_pulse", {cfg_err, busy, in_ready, ff_wr_req, ff_rd_req}, 5'b10000);
    @(negedge clk);
    chk("cfg_err_clear", {cfg_err, busy}, 2'b00);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, cfg_err, in_ready, ff_wr_req, ff_rd_req, win_valid}, 0);
    rst = 0;
    @(negedge clk);
    chk("post_reset_idle", {busy, done, cfg_err, in_ready, win_valid}, 0);
    run_frame(5, 1, 32);
    run_frame(4, 2, 16);
    run_frame(20, 1, 2);
    bad_cfg(2, 1);
    bad_cfg(5, 0);
    run_frame(6, 3, 8);
    run_frame(3, 1, 0);
    run_frame(6, 2, 4);
    for (int i = 0; i < 6; i++) run_frame($urandom_range(3, 12), $urandom_range(1, 4), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/row_window_ctrl.md
# row_window_ctrl

Sequencer for one `fifo_p1o3` instance (pop 1, read 3 consecutive entries), used as a 3-tap horizontal sliding-window buffer in the convolution datapath. It accepts a pixel stream row by row and writes it into the FIFO. It issues one window pop per output column, discards the two tail entries at the end of each row so windows never span rows, and tags the FIFO read data with window-valid and last markers. It sits between the input stream and the FIFO, and the FIFO's `rd_data` goes straight to the MAC array.

## Interface
Parameters:
- `DAT_WIDTH`, 8, pixel width; must match the FIFO.
- `FF_ADDR_WIDTH`, 3, FIFO address width; must match the FIFO.
- `DIM_WIDTH`, 10, width of the row-length and row-count fields.

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, reset; asynchronous, active-high.
- `start`, in, 1, pulse that latches the config; ignored unless idle.
- `cfg_row_len`, in, DIM_WIDTH, pixels per row; legal range ≥ 3.
- `cfg_num_rows`, in, DIM_WIDTH, rows per frame; legal range ≥ 1.
- `busy`, out, 1, high from accepted start until done.
- `done`, out, 1, one-cycle pulse at frame end.
- `cfg_err`, out, 1, one-cycle pulse when a start carries an illegal config.
- `in_valid`, in, 1, input pixel valid.
- `in_data`, in, DAT_WIDTH, input pixel.
- `in_ready`, out, 1, controller can accept a pixel.
- `out_stall`, in, 1, downstream back-pressure; blocks window pops.
- `ff_wr_req`, out, 1, FIFO write request.
- `ff_wr_data`, out, DAT_WIDTH, FIFO write data.
- `ff_rd_req`, out, 1, FIFO pop request.
- `ff_rd_data_val`, in, 1, FIFO read-data valid.
- `ff_data_counter`, in, FF_ADDR_WIDTH+1, FIFO occupancy.
- `ff_full`, in, 1, FIFO full flag.
- `win_valid`, out, 1, FIFO `rd_data` holds a real window.
- `win_last`, out, 1, window is the last one of its row.
- `win_last_row`, out, 1, window belongs to the last row.

## Operation
- **States:** IDLE, ROW, DRAIN, DONE.
- **IDLE:**
  - On `start` with `cfg_row_len`≥3 and `cfg_num_rows`≥1: latch both values, clear `row_cnt`, `wr_col`, `rd_col`, then go to ROW.
  - On `start` with an illegal config: pulse `cfg_err` and stay in IDLE.
- **ROW, write side:**
  - `in_ready` = ROW & (`wr_col` < row_len) & ~`ff_full`.
  - `ff_wr_req` = `in_valid` & `in_ready`, with `ff_wr_data` = `in_data` (combinational).
  - `wr_col` increments on each accepted write.
- **ROW, read side:**
  - `ff_rd_req` = ROW & (`rd_col` < row_len−2) & (`ff_data_counter` ≥ 3) & ~`out_stall`.
  - `rd_col` increments on each pop.
  - Writes and pops may occur in the same cycle.
- **ROW → DRAIN:** taken when a pop makes `rd_col` = row_len−2. At that point every pixel of the row has been written and exactly 2 entries remain in the FIFO.
- **DRAIN:**
  - Assert `ff_rd_req` for exactly 2 consecutive cycles, regardless of `out_stall`. These are discard pops.
  - `in_ready` = 0, so the next row never enters the FIFO before the current row is flushed.
  - After the 2nd pop: if `row_cnt` = num_rows−1, go to DONE. Otherwise go to ROW with `row_cnt`+1 and both column counters cleared.
- **DONE:** `done` = 1 for one cycle, then go to IDLE.
- **Tag pipeline:** one register stage matching the FIFO's 1-cycle read latency.
  - `keep_q` ← pop issued in ROW.
  - `last_q` ← that pop had `rd_col` = row_len−3.
  - `lrow_q` ← `row_cnt` = num_rows−1.
  - `win_valid` = `ff_rd_data_val` & `keep_q`.
  - `win_last` = `win_valid` & `last_q`.
  - `win_last_row` = `win_valid` & `lrow_q`.
  - Discard pops therefore produce `ff_rd_data_val`=1 with `win_valid`=0.
- **Counts:** each row yields exactly row_len−2 windows. Counter comparisons are at DIM_WIDTH; row_len−2 and row_len−3 are computed once at latch time.
- **`busy`:** 1 in ROW, DRAIN and DONE.
- **Reset:** reset mid-operation returns immediately to IDLE with every register cleared. The FIFO shares `rst` and the system guarantees both are reset together.

## Timing
- Reset values of all outputs are 0, including `in_ready`, `busy` and the tag registers.
- `start` accepted at edge t: ROW from t+1; `in_ready` can be 1 in cycle t+1.
- A window pop in cycle t gives `win_valid` in cycle t+1.
- Last window pop of a row in cycle t:
  - `win_last` at t+1.
  - Discard pops at t+1 and t+2.
  - Next row's `in_ready` earliest at t+3.
- Final row: `done` in cycle t+3, IDLE at t+4.
- Back-to-back operation:
  - A write can land every cycle.
  - Window pops start once occupancy reaches 3, so the first pop is earliest 3 cycles after the first write edge.
  - Sustained throughput is 1 window per cycle.
- `out_stall` is sampled combinationally and only gates new pops. A window already popped is presented the next cycle regardless of `out_stall`.
- `start` while busy has no effect.

## Structure
- **Shared package:** state encoding constants (IDLE, ROW, DRAIN, DONE) and the window size constant `WIN_TAPS`=3, from which the tail-drain count (`WIN_TAPS`−1 = 2) is derived.
- **Sub-modules:** none. The FIFO is a sibling instance wired by the parent. The controller holds the FSM, three counters and the tag stage only.

## Test plan
- **Basic frame:** row_len=5, num_rows=1, pixels 1..5 streamed every cycle. Expect 3 `win_valid` cycles with `rd_data` {3,2,1}, {4,3,2}, {5,4,3}. `win_last` and `win_last_row` are on the third only. Expect 2 discard pops, then `done` 3 cycles after the last window pop.
- **Row isolation:** row_len=4, num_rows=2, pixels 10..13 then 20..23. Expect windows {12,11,10}, {13,12,11}, {22,21,20}, {23,22,21}. No window mixes 1x and 2x values. `in_ready` stays 0 during DRAIN.
- **Long row:** row_len=20 with the FIFO depth of 8 and `out_stall` held high for 10 cycles mid-row. `in_ready` drops while `ff_full`=1, no pixel is lost, and all 18 windows appear in order.
- **Illegal config:** `start` with row_len=2, then `start` with num_rows=0. Each gives a one-cycle `cfg_err` pulse, with `busy` staying 0 and no FIFO activity.
- **Reset mid-operation:** assert `rst` in the middle of row 2 of 3. All outputs are 0 immediately (asynchronous). A new `start` with row_len=3 yields exactly one window.
- **Start while busy:** a `start` pulse in DRAIN with a different config. It is ignored and the original frame completes unchanged.
